// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates Icache fills and Dcache fills/write-backs onto one memory port.
// Rev 1.0. Optional macro ARB_RR_EN enables last-served IC/DC fairness instead of fixed priority.
`default_nettype none

module mem_arbiter #(
  parameter int REG_SIZE = 32,
  parameter int WIDTH    = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ic_read_req,
  input  logic [REG_SIZE-1:0] ic_read_addr,
  output logic                ic_read_ack,
  output logic [WIDTH-1:0]    ic_read_data,
  input  logic                dc_read_req,
  input  logic [REG_SIZE-1:0] dc_read_addr,
  output logic                dc_read_ack,
  output logic [WIDTH-1:0]    dc_read_data,
  input  logic                dc_write_req,
  input  logic [REG_SIZE-1:0] dc_write_addr,
  input  logic [WIDTH-1:0]    dc_write_data,
  output logic                dc_write_ack,
  output logic                mem_enable,
  output logic                mem_rw,
  input  logic                mem_ack,
  output logic [REG_SIZE-1:0] mem_addr,
  input  logic [WIDTH-1:0]    mem_data_in,
  output logic [WIDTH-1:0]    mem_data_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {GNT_IC = 2'd0, GNT_DR = 2'd1, GNT_DW = 2'd2} grant_t;

  state_t state;
  grant_t grant;
  grant_t pick;

`ifdef ARB_RR_EN
  logic last_ic;

  // DC wins unless IC is also waiting and DC was the side served last.
  always_comb begin
    pick = GNT_IC;
    if ((dc_write_req || dc_read_req) && (!ic_read_req || last_ic))
      pick = dc_write_req ? GNT_DW : GNT_DR;
  end
`else
  always_comb begin
    pick = GNT_IC;
    if (dc_write_req || dc_read_req)
      pick = dc_write_req ? GNT_DW : GNT_DR;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= GNT_IC;
      ic_read_ack  <= 1'b0;
      dc_read_ack  <= 1'b0;
      dc_write_ack <= 1'b0;
      mem_enable   <= 1'b0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      ic_read_data <= '0;
      dc_read_data <= '0;
`ifdef ARB_RR_EN
      last_ic      <= 1'b1;
`endif
    end else begin
      ic_read_ack  <= 1'b0;
      dc_read_ack  <= 1'b0;
      dc_write_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (ic_read_req || dc_read_req || dc_write_req) begin
            state      <= BUSY;
            grant      <= pick;
            mem_enable <= 1'b1;
            mem_rw     <= (pick == GNT_DW);
            case (pick)
              GNT_DW: begin
                mem_addr     <= dc_write_addr;
                mem_data_out <= dc_write_data;
              end
              GNT_DR:  mem_addr <= dc_read_addr;
              default: mem_addr <= ic_read_addr;
            endcase
`ifdef ARB_RR_EN
            last_ic <= (pick == GNT_IC);
`endif
          end
        end
        BUSY: begin
          // Ack is registered here so it is high for exactly the RESP cycle.
          if (mem_ack) begin
            state      <= RESP;
            mem_enable <= 1'b0;
            case (grant)
              GNT_DW: dc_write_ack <= 1'b1;
              GNT_DR: begin
                dc_read_ack  <= 1'b1;
                dc_read_data <= mem_data_in;
              end
              default: begin
                ic_read_ack  <= 1'b1;
                ic_read_data <= mem_data_in;
              end
            endcase
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a responding memory model.
`default_nettype none

module tb_mem_arbiter;
  localparam int RS = 32;
  localparam int W  = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_read_req, dc_read_req, dc_write_req;
  logic [RS-1:0] ic_read_addr, dc_read_addr, dc_write_addr;
  logic [W-1:0]  dc_write_data;
  logic          ic_read_ack, dc_read_ack, dc_write_ack;
  logic [W-1:0]  ic_read_data, dc_read_data;
  logic          mem_enable, mem_rw, mem_ack;
  logic [RS-1:0] mem_addr;
  logic [W-1:0]  mem_data_in, mem_data_out;

  mem_arbiter #(.REG_SIZE(RS), .WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .ic_read_req(ic_read_req), .ic_read_addr(ic_read_addr),
    .ic_read_ack(ic_read_ack), .ic_read_data(ic_read_data),
    .dc_read_req(dc_read_req), .dc_read_addr(dc_read_addr),
    .dc_read_ack(dc_read_ack), .dc_read_data(dc_read_data),
    .dc_write_req(dc_write_req), .dc_write_addr(dc_write_addr),
    .dc_write_data(dc_write_data), .dc_write_ack(dc_write_ack),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           port;   // 0 = ic read, 1 = dc read, 2 = dc write
    logic [RS-1:0] addr;
    logic [W-1:0]  data;
  } txn_t;

  txn_t         exp_q[$];
  txn_t         ack_q[$];
  logic [W-1:0] m_ic = '0;
  logic [W-1:0] m_dc = '0;
  bit           mem_hold = 1'b0;
  bit           stray = 1'b0;
  bit           last_ic = 1'b1;
  int           checks = 0;
  int           failures = 0;

  function automatic logic [W-1:0] mem_word(input logic [RS-1:0] a);
    return (a == 32'h100) ? 64'hDEADBEEF_DEADBEEF : {~a, a};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory: acks after a random 0..3 cycle wait, abandons on mem_enable falling.
  initial begin
    int cnt;
    cnt = 2;
    mem_ack = 1'b0;
    mem_data_in = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_data_in = {$urandom, $urandom};
      if (stray) begin
        mem_ack = 1'b1;
        stray = 1'b0;
      end else if (mem_enable) begin
        if (cnt == 0 && !mem_hold) begin
          mem_ack = 1'b1;
          mem_data_in = mem_word(mem_addr);
          cnt = $urandom_range(0, 3);
        end else if (cnt > 0) begin
          cnt--;
        end
      end else begin
        cnt = $urandom_range(0, 3);
      end
    end
  end

  // Monitor: pops expected transactions when memory starts one and when an ack appears.
  initial begin
    bit   prev_en;
    txn_t cur;
    txn_t t;
    int   n;
    int   got;
    prev_en = 1'b0;
    cur = '{port: 0, addr: '0, data: '0};
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_en = 1'b0;
        continue;
      end
      n = int'(ic_read_ack) + int'(dc_read_ack) + int'(dc_write_ack);
      if (n != 0) begin
        chk("ack_onehot", W'(n), W'(1));
        got = ic_read_ack ? 0 : (dc_read_ack ? 1 : 2);
        if (ack_q.size() == 0) begin
          chk("spurious_ack", W'(got), W'(99));
        end else begin
          t = ack_q.pop_front();
          chk("ack_port", W'(got), W'(t.port));
          if (t.port == 0) m_ic = mem_word(t.addr);
          if (t.port == 1) m_dc = mem_word(t.addr);
        end
      end
      chk("ic_read_data", ic_read_data, m_ic);
      chk("dc_read_data", dc_read_data, m_dc);
      if (mem_enable && !prev_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_mem_txn", W'(mem_addr), W'(0));
          cur = '{port: 0, addr: mem_addr, data: '0};
        end else begin
          cur = exp_q.pop_front();
          chk("mem_addr", W'(mem_addr), W'(cur.addr));
          chk("mem_rw", W'(mem_rw), W'(cur.port == 2));
          if (cur.port == 2) chk("mem_data_out", mem_data_out, cur.data);
        end
      end else if (mem_enable) begin
        chk("mem_addr_stable", W'(mem_addr), W'(cur.addr));
        chk("mem_rw_stable", W'(mem_rw), W'(cur.port == 2));
        if (cur.port == 2) chk("mem_data_out_stable", mem_data_out, cur.data);
      end
      prev_en = mem_enable;
    end
  end

  task automatic push_txn(input int port, input logic [RS-1:0] a, input logic [W-1:0] d);
    txn_t t;
    t = '{port: port, addr: a, data: d};
    exp_q.push_back(t);
    ack_q.push_back(t);
  endtask

  // Raise the requests in 'set' together and hold each until its ack is seen.
  task automatic run_batch(input bit [2:0] set, input logic [RS-1:0] ia, input logic [RS-1:0] ra,
                           input logic [RS-1:0] wa, input logic [W-1:0] wd);
    bit ic, dr, dw, take_dc, done;
    ic = set[0]; dr = set[1]; dw = set[2];
    while (ic || dr || dw) begin
`ifdef ARB_RR_EN
      take_dc = (dr || dw) && (!ic || last_ic);
`else
      take_dc = dr || dw;
`endif
      if (take_dc) begin
        if (dw) begin push_txn(2, wa, wd); dw = 1'b0; end
        else    begin push_txn(1, ra, '0); dr = 1'b0; end
        last_ic = 1'b0;
      end else begin
        push_txn(0, ia, '0);
        ic = 1'b0;
        last_ic = 1'b1;
      end
    end
    ic_read_addr = ia; dc_read_addr = ra; dc_write_addr = wa; dc_write_data = wd;
    ic_read_req = set[0]; dc_read_req = set[1]; dc_write_req = set[2];
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk); #1;
      if (ic_read_ack)  ic_read_req = 1'b0;
      if (dc_read_ack)  dc_read_req = 1'b0;
      if (dc_write_ack) dc_write_req = 1'b0;
      done = !(ic_read_req || dc_read_req || dc_write_req);
    end
    chk("batch_done", W'(done), W'(1));
    ic_read_req = 1'b0; dc_read_req = 1'b0; dc_write_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_enable(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk); #1;
      seen = mem_enable;
    end
    chk(name, W'(seen), W'(1));
  endtask

  initial begin
    bit got_ack;
    reset = 1'b1;
    ic_read_req = 1'b0; dc_read_req = 1'b0; dc_write_req = 1'b0;
    ic_read_addr = '0; dc_read_addr = '0; dc_write_addr = '0; dc_write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_enable", W'(mem_enable), W'(0));
    chk("rst_mem_rw", W'(mem_rw), W'(0));
    chk("rst_acks", W'({ic_read_ack, dc_read_ack, dc_write_ack}), W'(0));
    chk("rst_mem_addr", W'(mem_addr), W'(0));
    chk("rst_mem_data_out", mem_data_out, '0);
    chk("rst_ic_data", ic_read_data, '0);
    chk("rst_dc_data", dc_read_data, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single Icache fill and a Dcache write-back, then all three at once.
    run_batch(3'b001, 32'h100, '0, '0, '0);
    run_batch(3'b100, '0, '0, 32'h40, 64'h1234_5678_9ABC_DEF0);
    run_batch(3'b111, 32'h200, 32'h300, 32'h400, 64'hA5A5_0000_FFFF_5A5A);

    for (int i = 0; i < 40; i++)
      run_batch(3'($urandom_range(1, 7)), {$urandom} & 32'hFFFF_FFF0,
                {$urandom} & 32'hFFFF_FFF0, {$urandom} & 32'hFFFF_FFF0, {$urandom, $urandom});

    // Stray mem_ack while idle must change nothing.
    stray = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_no_enable", W'(mem_enable), W'(0));

    // Dcache fill whose request is dropped mid-transaction still completes.
    mem_hold = 1'b1;
    push_txn(1, 32'h0000_0880, '0);
    dc_read_addr = 32'h0000_0880;
    dc_read_req = 1'b1;
    wait_enable("drop_enable_seen");
    dc_read_req = 1'b0;
    last_ic = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_hold = 1'b0;
    got_ack = 1'b0;
    for (int c = 0; c < 50 && !got_ack; c++) begin
      @(posedge clk); #1;
      got_ack = dc_read_ack;
    end
    chk("drop_ack_seen", W'(got_ack), W'(1));
    repeat (2) @(posedge clk);
    #1;

    // Reset while waiting on memory abandons the transaction.
    mem_hold = 1'b1;
    push_txn(0, 32'h0000_0CC0, '0);
    ic_read_addr = 32'h0000_0CC0;
    ic_read_req = 1'b1;
    wait_enable("abort_enable_seen");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    ic_read_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    ack_q.delete();
    exp_q.delete();
    m_ic = '0; m_dc = '0;
    last_ic = 1'b1;
    mem_hold = 1'b0;
    chk("abort_mem_enable", W'(mem_enable), W'(0));
    chk("abort_no_ack", W'({ic_read_ack, dc_read_ack, dc_write_ack}), W'(0));
    @(posedge clk); #1;
    chk("abort_still_idle", W'(mem_enable), W'(0));
    run_batch(3'b001, 32'h0000_0D00, '0, '0, '0);

    for (int i = 0; i < 10; i++)
      run_batch(3'($urandom_range(1, 7)), {$urandom}, {$urandom}, {$urandom}, {$urandom, $urandom});

    repeat (4) @(posedge clk);
    #1;
    chk("exp_q_drained", W'(exp_q.size()), W'(0));
    chk("ack_q_drained", W'(ack_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have the ports `clk`, `reset`, and port widths `REG_SIZE` (address) and `WIDTH` (line) from define.v.
- clk  in  1  rising-edge clock
- reset  in  1  sync active-high reset
- ic_read_req  in  1  Icache line-fill request
- ic_read_addr  in  REG_SIZE  Icache line address
- ic_read_ack  out  1  one-cycle completion pulse
- ic_read_data  out  WIDTH  fill data
- dc_read_req  in  1  Dcache line-fill request
- dc_read_addr  in  REG_SIZE  Dcache fill address
- dc_read_ack  out  1  one-cycle completion pulse
- dc_read_data  out  WIDTH  fill data
- dc_write_req  in  1  Dcache write-back request
- dc_write_addr  in  REG_SIZE  write-back address
- dc_write_data  in  WIDTH  write-back line
- dc_write_ack  out  1  one-cycle completion pulse
- mem_enable  out  1  memory transaction active
- mem_rw  out  1  1=write, 0=read
- mem_ack  in  1  memory completion, one cycle
- mem_addr  out  REG_SIZE  memory address
- mem_data_in  in  WIDTH  read data from memory, valid with mem_ack
- mem_data_out  out  WIDTH  write data to memory

Function
REQ-003 SHALL implement the FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-004 In IDLE, each rising edge SHALL sample the requests.
- If any request is high, the arbiter SHALL go to BUSY and latch the grant, mem_addr, mem_rw and mem_data_out.
- If no request is high, it SHALL stay in IDLE.
REQ-005 Without ARB_RR_EN, grant priority SHALL be dc_write > dc_read > ic_read.
REQ-006 In BUSY, mem_enable SHALL be 1.
- mem_addr, mem_rw and mem_data_out SHALL stay stable until mem_ack.
- The wait in BUSY is unbounded.
REQ-007 On an edge with mem_ack=1 in BUSY, the arbiter SHALL:
- go to RESP and drive mem_enable 0;
- for a read grant, register mem_data_in into the granted port's read_data.
REQ-008 In RESP, exactly the granted port's ack SHALL be 1 for one cycle; the next state SHALL be IDLE.
REQ-009 Requesters SHALL deassert req on the edge at which they see ack; the IDLE sample that follows therefore does not re-grant the same request.
REQ-010 Minimum latency SHALL be 3 cycles (req sampled at edge k, BUSY at k+1, mem_ack at k+1, ack high in cycle k+2..k+3).
REQ-011 ic_read_data and dc_read_data SHALL hold their value until the next completed read on the same port.
REQ-012 A request dropped while BUSY SHALL NOT abort the transaction; the ack SHALL still be issued.
REQ-013 mem_ack while IDLE or RESP SHALL be ignored.
REQ-014 Requests arriving while BUSY/RESP SHALL wait, and SHALL be arbitrated on the next IDLE sample.
REQ-015 At most one ack SHALL be high in any cycle.

Reset
REQ-016 On reset, the arbiter SHALL:
- go to state IDLE;
- drive all acks, mem_enable and mem_rw to 0;
- drive mem_addr, mem_data_out, ic_read_data and dc_read_data to 0.
REQ-017 Reset during BUSY SHALL abandon the transaction: mem_enable SHALL be 0 the next cycle and no ack SHALL be issued. The memory model SHALL treat mem_enable falling as an abort.

Configuration
REQ-018 With macro ARB_RR_EN defined, the arbiter SHALL use a last-served flag for arbitration:
- Arbitration is between IC (ic_read) and DC (dc_write, dc_read).
- When both IC and DC request, the side not served last SHALL win.
- Within DC, dc_write SHALL still precede dc_read.
- The flag SHALL reset to "IC served last".
REQ-019 Without ARB_RR_EN, the flag SHALL be absent and fixed priority per REQ-005 SHALL apply.

Verification
REQ-020 Single Icache read: ic_read_req=1, addr=0x100; memory acks 2 cycles after enable with 0xDEADBEEF...
- mem_enable=1, mem_rw=0, mem_addr=0x100.
- ic_read_ack pulses 1 cycle; ic_read_data=0xDEADBEEF...
REQ-021 Dcache write-back: dc_write_req=1, addr=0x40, data=0x1234...
- mem_rw=1, mem_data_out=0x1234... stable until mem_ack.
- dc_write_ack pulses; read_data ports are unchanged.
REQ-022 All three requests raised in the same cycle, no ARB_RR_EN.
- Service order is dc_write, dc_read, ic_read.
- Three acks, each a single cycle, never overlapping.
REQ-023 With ARB_RR_EN, ic_read_req and dc_read_req held continuously for 4 transactions.
- Grants alternate DC, IC, DC, IC (first DC, since reset flag is "IC last").
REQ-024 Reset asserted during BUSY with mem_ack never given.
- Next cycle: mem_enable=0, state IDLE, no ack.
- After reset, a fresh ic request completes normally.
REQ-025 mem_ack pulsed while IDLE; then dc_read_req dropped mid-BUSY.
- The stray ack produces no output change.
- The dropped-request transaction still completes with dc_read_ack.
